// File: rtl/ps2_rx_fifo.sv
// PS/2 receive front-end: synchronises the raw PS/2 lines, deserialises
// 11-bit frames, folds E0/F0 prefixes into flags and queues key events
// in a show-ahead FIFO drained with a valid/ready handshake.
// The break flag output is named key_release because "release" is a
// reserved word in SystemVerilog.
module ps2_rx_fifo #(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic       system_clk,
    input  logic       reset,
    input  logic       PS2_clk,
    input  logic       PS2_data,
    output logic [7:0] scan_code,
    output logic       extended,
    output logic       key_release,
    output logic       scan_valid,
    input  logic       scan_ready,
    output logic       frame_error,
    output logic       overflow
);

    localparam int AW   = $clog2(FIFO_DEPTH);
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic            clk_meta, clk_s, clk_d;
    logic            dat_meta, dat_s;
    logic            fall;

    state_t          state;
    logic [2:0]      bit_cnt;
    logic [7:0]      shift_reg;
    logic            parity_bit;
    logic [WD_W-1:0] wd_cnt;
    logic            ext_pend, brk_pend;

    logic            frame_good;
    logic            push_req;
    logic [9:0]      push_entry;

    logic [9:0]      mem [FIFO_DEPTH];
    logic [AW:0]     wr_ptr, rd_ptr;
    logic            full, empty, pop, push_ok;
    logic [9:0]      head;

    // Two-flop synchronisers on both PS/2 lines plus a delayed clock copy for edge detection
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            clk_meta <= 1'b0;
            clk_s    <= 1'b0;
            clk_d    <= 1'b0;
            dat_meta <= 1'b0;
            dat_s    <= 1'b0;
        end else begin
            clk_meta <= PS2_clk;
            clk_s    <= clk_meta;
            clk_d    <= clk_s;
            dat_meta <= PS2_data;
            dat_s    <= dat_meta;
        end
    end

    assign fall = clk_d & ~clk_s;

    // Frame validity and the event entry that a good stop bit would push
    always_comb begin
        frame_good = (^{shift_reg, parity_bit}) & dat_s;
        push_req   = 1'b0;
        push_entry = {ext_pend, brk_pend, shift_reg};
        if ((state == STOP) && fall && frame_good &&
            (shift_reg != 8'hE0) && (shift_reg != 8'hF0)) begin
            push_req = 1'b1;
        end
    end

    // Frame receiver FSM with watchdog, prefix folding and error pulse
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            bit_cnt     <= 3'd0;
            shift_reg   <= 8'h00;
            parity_bit  <= 1'b0;
            wd_cnt      <= '0;
            ext_pend    <= 1'b0;
            brk_pend    <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_error <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (fall) begin
                        if (!dat_s) begin
                            state   <= DATA;
                            bit_cnt <= 3'd0;
                        end else begin
                            frame_error <= 1'b1;
                        end
                    end
                end
                default: begin
                    if (fall) begin
                        wd_cnt <= '0;
                        case (state)
                            DATA: begin
                                shift_reg <= {dat_s, shift_reg[7:1]};
                                bit_cnt   <= bit_cnt + 3'd1;
                                if (bit_cnt == 3'd7) begin
                                    state <= PARITY;
                                end
                            end
                            PARITY: begin
                                parity_bit <= dat_s;
                                state      <= STOP;
                            end
                            STOP: begin
                                state <= IDLE;
                                if (frame_good) begin
                                    if (shift_reg == 8'hE0) begin
                                        ext_pend <= 1'b1;
                                    end else if (shift_reg == 8'hF0) begin
                                        brk_pend <= 1'b1;
                                    end else begin
                                        ext_pend <= 1'b0;
                                        brk_pend <= 1'b0;
                                    end
                                end else begin
                                    frame_error <= 1'b1;
                                    ext_pend    <= 1'b0;
                                    brk_pend    <= 1'b0;
                                end
                            end
                            default: state <= IDLE;
                        endcase
                    end else if (wd_cnt == WD_LIMIT) begin
                        frame_error <= 1'b1;
                        ext_pend    <= 1'b0;
                        brk_pend    <= 1'b0;
                        wd_cnt      <= '0;
                        state       <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop     = ~empty & scan_ready;
    assign push_ok = push_req & (~full | pop);

    // FIFO pointers and the overflow pulse for events dropped while full
    always_ff @(posedge system_clk or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
        end else begin
            overflow <= push_req & full & ~pop;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // FIFO storage; contents need no reset because the pointers gate visibility
    always_ff @(posedge system_clk) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= push_entry;
        end
    end

    assign head        = mem[rd_ptr[AW-1:0]];
    assign scan_valid  = ~empty;
    assign scan_code   = empty ? 8'h00 : head[7:0];
    assign key_release = empty ? 1'b0  : head[8];
    assign extended    = empty ? 1'b0  : head[9];

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed testbench for ps2_rx_fifo: drives PS/2 frames bit by bit and
// checks the event FIFO, error and overflow pulses against hand-computed values.
module tb_ps2_rx_fifo;

    localparam int TIMEOUT = 5000;

    logic       system_clk = 1'b0;
    logic       reset;
    logic       PS2_clk;
    logic       PS2_data;
    logic [7:0] scan_code;
    logic       extended;
    logic       key_release;
    logic       scan_valid;
    logic       scan_ready;
    logic       frame_error;
    logic       overflow;

    int tests_run    = 0;
    int tests_failed = 0;

    int         fe_count     = 0;
    int         ov_count     = 0;
    int         valid_cycles = 0;
    logic [7:0] cap_code     = 8'h00;
    logic       cap_ext      = 1'b0;
    logic       cap_rel      = 1'b0;

    int fe_base, ov_base, valid_base;

    ps2_rx_fifo #(.FIFO_DEPTH(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
        .system_clk (system_clk),
        .reset      (reset),
        .PS2_clk    (PS2_clk),
        .PS2_data   (PS2_data),
        .scan_code  (scan_code),
        .extended   (extended),
        .key_release(key_release),
        .scan_valid (scan_valid),
        .scan_ready (scan_ready),
        .frame_error(frame_error),
        .overflow   (overflow)
    );

    // 100 MHz-style system clock
    always #5 system_clk = ~system_clk;

    // Count pulse cycles and capture the head whenever an entry is visible
    always @(negedge system_clk) begin
        if (frame_error) fe_count = fe_count + 1;
        if (overflow)    ov_count = ov_count + 1;
        if (scan_valid) begin
            valid_cycles = valid_cycles + 1;
            cap_code     = scan_code;
            cap_ext      = extended;
            cap_rel      = key_release;
        end
    end

    task automatic check_output(input string tag, input logic [31:0] observed,
                                input logic [31:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge system_clk);
    endtask

    // One PS/2 bit: data set while clock high, then a 20-cycle low phase
    task automatic ps2_bit(input logic b);
        PS2_data = b;
        idle_cycles(10);
        PS2_clk = 1'b0;
        idle_cycles(20);
        PS2_clk = 1'b1;
        idle_cycles(10);
    endtask

    task automatic send_frame(input logic [7:0] code, input logic par, input logic stp);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(code[i]);
        ps2_bit(par);
        ps2_bit(stp);
        PS2_data = 1'b1;
        idle_cycles(10);
    endtask

    task automatic pop_one();
        scan_ready = 1'b1;
        @(negedge system_clk);
        scan_ready = 1'b0;
        @(negedge system_clk);
    endtask

    task automatic check_head(input string tag, input logic [7:0] code,
                              input logic ext, input logic rel);
        check_output({tag, "_valid"}, 32'(scan_valid), 32'd1);
        check_output({tag, "_code"}, 32'(scan_code), 32'(code));
        check_output({tag, "_ext"}, 32'(extended), 32'(ext));
        check_output({tag, "_rel"}, 32'(key_release), 32'(rel));
    endtask

    task automatic check_all_zero(input string tag);
        check_output({tag, "_valid"}, 32'(scan_valid), 32'd0);
        check_output({tag, "_code"}, 32'(scan_code), 32'd0);
        check_output({tag, "_ext"}, 32'(extended), 32'd0);
        check_output({tag, "_rel"}, 32'(key_release), 32'd0);
        check_output({tag, "_ferr"}, 32'(frame_error), 32'd0);
        check_output({tag, "_ovf"}, 32'(overflow), 32'd0);
    endtask

    initial begin
        logic [7:0] fill_codes [9];
        logic       fill_par   [9];

        fill_codes = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
        fill_par   = '{1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0,  1'b1};

        // Reset state
        reset      = 1'b0;
        PS2_clk    = 1'b1;
        PS2_data   = 1'b1;
        scan_ready = 1'b0;
        idle_cycles(5);
        check_all_zero("reset");
        reset = 1'b1;
        idle_cycles(10);

        // Single make code consumed immediately
        scan_ready = 1'b1;
        valid_base = valid_cycles;
        send_frame(8'h1C, 1'b0, 1'b1);
        scan_ready = 1'b0;
        check_output("make_valid_cycles", 32'(valid_cycles - valid_base), 32'd1);
        check_output("make_code", 32'(cap_code), 32'h1C);
        check_output("make_ext", 32'(cap_ext), 32'd0);
        check_output("make_rel", 32'(cap_rel), 32'd0);
        check_output("make_empty_after", 32'(scan_valid), 32'd0);

        // Break sequence F0 1C
        send_frame(8'hF0, 1'b1, 1'b1);
        check_output("brk_prefix_no_entry", 32'(scan_valid), 32'd0);
        send_frame(8'h1C, 1'b0, 1'b1);
        check_head("brk", 8'h1C, 1'b0, 1'b1);
        pop_one();
        check_output("brk_popped", 32'(scan_valid), 32'd0);

        // Extended break E0 F0 75, then plain 45
        send_frame(8'hE0, 1'b0, 1'b1);
        send_frame(8'hF0, 1'b1, 1'b1);
        check_output("ext_prefix_no_entry", 32'(scan_valid), 32'd0);
        send_frame(8'h75, 1'b0, 1'b1);
        check_head("extbrk", 8'h75, 1'b1, 1'b1);
        pop_one();
        send_frame(8'h45, 1'b0, 1'b1);
        check_head("after_ext", 8'h45, 1'b0, 1'b0);
        pop_one();

        // Parity error
        fe_base = fe_count;
        send_frame(8'h1C, 1'b1, 1'b1);
        check_output("parity_ferr", 32'(fe_count - fe_base), 32'd1);
        check_output("parity_no_entry", 32'(scan_valid), 32'd0);

        // Stop bit error
        fe_base = fe_count;
        send_frame(8'h1C, 1'b0, 1'b0);
        check_output("stop_ferr", 32'(fe_count - fe_base), 32'd1);
        check_output("stop_no_entry", 32'(scan_valid), 32'd0);

        // Prefix cleared by an error: F0 then bad frame then 1C gives a make code
        send_frame(8'hF0, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check_head("err_clears_pend", 8'h1C, 1'b0, 1'b0);
        pop_one();

        // Watchdog: stall after 4 data bits
        fe_base = fe_count;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(1'b1);
        idle_cycles(TIMEOUT + 100);
        check_output("timeout_ferr", 32'(fe_count - fe_base), 32'd1);
        check_output("timeout_no_entry", 32'(scan_valid), 32'd0);
        send_frame(8'h45, 1'b0, 1'b1);
        check_head("after_timeout", 8'h45, 1'b0, 1'b0);
        pop_one();

        // Full FIFO and overflow
        ov_base = ov_count;
        for (int i = 0; i < 8; i++) send_frame(fill_codes[i], fill_par[i], 1'b1);
        check_output("fill_no_ovf", 32'(ov_count - ov_base), 32'd0);
        send_frame(fill_codes[8], fill_par[8], 1'b1);
        check_output("ovf_pulse", 32'(ov_count - ov_base), 32'd1);
        for (int i = 0; i < 8; i++) begin
            check_output($sformatf("drain%0d_code", i), 32'(scan_code), 32'(fill_codes[i]));
            pop_one();
        end
        check_output("drain_empty", 32'(scan_valid), 32'd0);

        // Reset mid-frame with an entry pending
        send_frame(8'h45, 1'b0, 1'b1);
        check_output("pre_reset_valid", 32'(scan_valid), 32'd1);
        fe_base = fe_count;
        ps2_bit(1'b0);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        reset = 1'b0;
        idle_cycles(2);
        check_all_zero("midreset");
        reset = 1'b1;
        PS2_data = 1'b1;
        idle_cycles(20);
        check_output("midreset_no_ferr", 32'(fe_count - fe_base), 32'd0);
        check_output("midreset_empty", 32'(scan_valid), 32'd0);
        send_frame(8'h16, 1'b0, 1'b1);
        check_head("after_reset", 8'h16, 1'b0, 1'b0);
        pop_one();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/ps2_rx_fifo.md
# ps2_rx_fifo

PS/2 receive front-end that sits directly upstream of the keyboard peripheral. It samples the asynchronous `PS2_clk`/`PS2_data` lines in the `system_clk` domain and deserialises 11-bit device frames. It checks start, parity and stop bits, folds `E0`/`F0` prefix bytes into flags, and buffers complete key events in a small FIFO with a valid/ready handshake for the keyboard register logic.

## Interface
- `FIFO_DEPTH`, 8: number of event entries; power of two, minimum 2.
- `TIMEOUT_CYCLES`, 5000: `system_clk` cycles allowed between PS/2 falling edges inside a frame before the frame is aborted.

- `system_clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `PS2_clk`  in  1  raw PS/2 clock line, asynchronous.
- `PS2_data`  in  1  raw PS/2 data line, asynchronous.
- `scan_code`  out  8  scan byte of the FIFO head entry; 0 when `scan_valid`=0.
- `extended`  out  1  head entry was preceded by `E0`; 0 when `scan_valid`=0.
- `release`  out  1  head entry was preceded by `F0` (break code); 0 when `scan_valid`=0.
- `scan_valid`  out  1  FIFO non-empty.
- `scan_ready`  in  1  consumer accepts the head entry this cycle.
- `frame_error`  out  1  one-cycle pulse on any rejected frame.
- `overflow`  out  1  one-cycle pulse when a completed event is dropped because the FIFO is full.

## Operation
- Synchroniser: two flops each on `PS2_clk` and `PS2_data` (`clk_s`, `dat_s`), plus one flop `clk_d` holding the previous `clk_s`. A fall is `clk_d & ~clk_s`. All bit sampling uses `dat_s` in the fall cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE: on a fall with `dat_s`=0, go to DATA with the bit count at 0. On a fall with `dat_s`=1, pulse `frame_error` and stay in IDLE.
  - DATA: on each fall, shift `dat_s` in LSB first. After the 8th bit, go to PARITY.
  - PARITY: on a fall, latch `dat_s`, then go to STOP.
  - STOP: on a fall, the frame is good if the 8 data bits plus the parity bit contain an odd number of ones and `dat_s`=1. Return to IDLE in both cases.
- Good frame decode:
  - Byte `E0` sets `ext_pend`.
  - Byte `F0` sets `brk_pend`.
  - Any other byte pushes the entry {`ext_pend`, `brk_pend`, byte} and clears both pending flags.
- Bad frame (parity or stop failure): pulse `frame_error`, discard the byte, clear both pending flags.
- Watchdog: a counter clears on every fall and increments in the non-IDLE states. When it reaches `TIMEOUT_CYCLES`, pulse `frame_error`, clear both pending flags and go to IDLE. The counter is held at 0 in IDLE.
- FIFO: show-ahead, 10-bit entries, read/write pointers one bit wider than the address so full and empty are distinguishable.
  - Pop when `scan_valid & scan_ready`.
  - Push while full with no pop: the entry is dropped and `overflow` pulses; pointers are unchanged.
  - Push and pop in the same cycle while full: both take effect, and the count stays at `FIFO_DEPTH`.
  - Push and pop in the same cycle with exactly one entry: both take effect, and `scan_valid` stays high showing the new entry.
- Pending flags persist across IDLE until consumed by a data byte, an error, a timeout or reset.

## Timing
- Reset (asynchronous assert, synchronous release) does the following:
  - All outputs go to 0.
  - FSM to IDLE; pointers, bit count, watchdog, pending flags and synchroniser flops to 0.
  - Reset asserted mid-frame discards the partial frame with no `frame_error` pulse.
- Fall detect: the fall cycle is 3 `system_clk` edges after `PS2_clk` falls (±1 cycle for metastability resolution).
- Push: the FIFO write occurs on the clock edge that ends the stop-bit fall cycle, so `scan_valid` and the head outputs are valid in the next cycle. `frame_error` and `overflow` are asserted in that same next cycle, for exactly one cycle.
- Pop: `scan_valid`/`scan_code` reflect the new head in the cycle after the handshake edge.
- Throughput is limited only by the PS/2 rate. The FIFO accepts one push and one pop per cycle.

## Test plan
- Single make code: frame `1C` (bits 0,00111000,0,1) with `scan_ready`=1 -> one-cycle `scan_valid`, `scan_code`=8'h1C, `extended`=0, `release`=0.
- Break sequence: frames `F0` (parity 1) then `1C` -> one entry {`release`=1, `extended`=0, 8'h1C}; no entry for `F0`.
- Extended break: frames `E0`, `F0`, `75` -> one entry {1, 1, 8'h75}. A following `45` -> {0, 0, 8'h45}.
- Errors:
  - `1C` sent with parity 1 -> `frame_error` pulse and no entry.
  - Stop bit 0 -> `frame_error` pulse.
  - A frame stalled after 4 bits for `TIMEOUT_CYCLES` -> `frame_error` pulse, then a clean `45` is received correctly.
- Full FIFO: `scan_ready`=0, send 9 codes with `FIFO_DEPTH`=8 -> the 9th gives an `overflow` pulse. Draining yields the first 8 codes in order, then `scan_valid`=0.
- Reset mid-frame: assert `reset`=0 after the 5th data bit -> all outputs 0 and no `frame_error`. A subsequent `16` frame yields `scan_code`=8'h16.
